// File: rtl/data_mem_responder.sv
// data_mem_responder
// Memory-side responder for the CPU data bus. It accepts one load or store
// request at a time and moves one byte per cycle through a byte-wide array, so
// every RISC-V access width and sign mode is handled here rather than in the
// CPU datapath. When the access completes it raises a one-cycle response strobe.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous, active-low reset
//   req_valid   request present; the requester holds it until req_ready
//   req_ready   responder idle and able to accept
//   ControlBus  {MemWriteEn, MemReadEn, RegWriteEn}; RegWriteEn is ignored
//   AddressBus  byte address; only the low ADDR_BITS bits are used
//   DataBusOut  store data; the low N bytes are used
//   funct3      access size/sign code (RISC-V load/store encoding)
//   DataBusIn   load result, held from one response to the next
//   resp_valid  one-cycle completion strobe
//   resp_err    qualifies resp_valid: the request was rejected
//
// state | meaning
// IDLE  | ready for a request
// XFER  | one byte of the access moves per cycle, index idx_q
// RESP  | response strobe cycle
module data_mem_responder #(
  parameter int MEM_SIZE  = 4096,
  parameter int ADDR_BITS = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  ControlBus,
  input  logic [63:0] AddressBus,
  input  logic [63:0] DataBusOut,
  input  logic [2:0]  funct3,
  output logic [63:0] DataBusIn,
  output logic        resp_valid,
  output logic        resp_err
);

  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

  state_t                 state_q, state_d;
  logic [2:0]             idx_q, idx_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [63:0]            wdata_q, wdata_d;
  logic [2:0]             f3_q, f3_d;
  logic                   wr_q, wr_d;
  logic                   err_q, err_d;
  logic [63:0]            buf_q, buf_d;
  logic [63:0]            rdata_q, rdata_d;

  // Backing store has no reset: rst never clears the contents.
  logic [7:0]             mem_q [MEM_SIZE];

  logic                   req_load, req_store, req_bad;
  logic [ADDR_BITS-1:0]   byte_addr;
  logic [2:0]             last_idx;
  logic [7:0]             wr_byte;
  logic                   wr_en;

  logic                   unused_bits;
  assign unused_bits = ^{ControlBus[0], AddressBus[63:ADDR_BITS]};

  function automatic logic [63:0] extend(input logic [2:0] f3, input logic [63:0] b);
    logic [63:0] r;
    case (f3)
      3'b000:  r = {{56{b[7]}},  b[7:0]};
      3'b001:  r = {{48{b[15]}}, b[15:0]};
      3'b010:  r = {{32{b[31]}}, b[31:0]};
      3'b100:  r = {56'd0, b[7:0]};
      3'b101:  r = {48'd0, b[15:0]};
      3'b110:  r = {32'd0, b[31:0]};
      default: r = b;
    endcase
    return r;
  endfunction

  assign req_store = ControlBus[2];
  assign req_load  = ControlBus[1];
  assign req_bad   = (req_store && req_load) ||
                     (req_load && funct3 == 3'b111) ||
                     (req_store && funct3[2]);

  // Address arithmetic is ADDR_BITS wide, so the access wraps past the top.
  assign byte_addr = addr_q + ADDR_BITS'(idx_q);
  assign last_idx  = 3'((4'd1 << f3_q[1:0]) - 4'd1);
  assign wr_byte   = wdata_q[{idx_q, 3'b000} +: 8];
  assign wr_en     = (state_q == XFER) && wr_q;

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_err   = (state_q == RESP) && err_q;
  assign DataBusIn  = rdata_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    wr_d    = wr_q;
    err_d   = err_q;
    buf_d   = buf_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid && (req_load || req_store)) begin
          addr_d  = AddressBus[ADDR_BITS-1:0];
          wdata_d = DataBusOut;
          f3_d    = funct3;
          wr_d    = req_store;
          idx_d   = 3'd0;
          buf_d   = 64'd0;
          err_d   = req_bad;
          if (req_bad) begin
            state_d = RESP;
            rdata_d = 64'd0;
          end else begin
            state_d = XFER;
          end
        end
      end
      XFER: begin
        if (!wr_q) buf_d[{idx_q, 3'b000} +: 8] = mem_q[byte_addr];
        idx_d = idx_q + 3'd1;
        if (idx_q == last_idx) begin
          state_d = RESP;
          // buf_d already holds the final byte gathered this cycle.
          rdata_d = wr_q ? 64'd0 : extend(f3_q, buf_d);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      addr_q  <= '0;
      wdata_q <= 64'd0;
      f3_q    <= 3'd0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      buf_q   <= 64'd0;
      rdata_q <= 64'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      buf_q   <= buf_d;
      rdata_q <= rdata_d;
    end
  end

  // A reset edge suppresses the write in flight; earlier bytes stay written.
  always_ff @(posedge clk) begin
    if (rst && wr_en) mem_q[byte_addr] <= wr_byte;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  ControlBus = 3'd0;
  logic [63:0] AddressBus = 64'd0;
  logic [63:0] DataBusOut = 64'd0;
  logic [2:0]  funct3 = 3'd0;
  logic [63:0] DataBusIn;
  logic        resp_valid;
  logic        resp_err;

  data_mem_responder #(.MEM_SIZE(4096), .ADDR_BITS(12)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .ControlBus(ControlBus), .AddressBus(AddressBus), .DataBusOut(DataBusOut),
    .funct3(funct3), .DataBusIn(DataBusIn), .resp_valid(resp_valid),
    .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [7:0] model_mem [4096];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  // Reference load: little-endian byte gather, then sign/zero extension.
  function automatic logic [63:0] model_load(input logic [11:0] a, input logic [2:0] f3);
    int n;
    logic [63:0] v;
    n = 1 << f3[1:0];
    v = 64'd0;
    for (int i = 0; i < n; i++) v = v | (64'(model_mem[12'(a + i)]) << (8 * i));
    if (!f3[2] && f3[1:0] != 2'b11 && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
    return v;
  endfunction

  task automatic do_req(input string tag, input logic [2:0] ctrl, input logic [63:0] addr,
                        input logic [63:0] wd, input logic [2:0] f3, output logic [63:0] got);
    bit wr, rd, bad;
    int n, lat, w;
    logic [63:0] exp_data;
    logic [11:0] a;
    wr = ctrl[2];
    rd = ctrl[1];
    a = addr[11:0];
    bad = (wr && rd) || (rd && f3 == 3'b111) || (wr && f3[2]);
    n = 1 << f3[1:0];
    exp_data = 64'd0;
    if (!bad) begin
      if (wr) for (int i = 0; i < n; i++) model_mem[12'(a + i)] = wd[8*i +: 8];
      else exp_data = model_load(a, f3);
    end
    w = 0;
    while (req_ready !== 1'b1 && w < 20) begin
      @(posedge clk); #1; w++;
    end
    check({tag, "_ready"}, 64'(req_ready), 64'd1);
    req_valid  = 1'b1;
    ControlBus = ctrl;
    AddressBus = addr;
    DataBusOut = wd;
    funct3     = f3;
    @(posedge clk); #1;
    lat = 0;
    while (resp_valid !== 1'b1 && lat < 20) begin
      // Garbage while busy: must be ignored and must not disturb the capture.
      req_valid  = 1'($urandom);
      ControlBus = 3'($urandom);
      AddressBus = {$urandom, $urandom};
      DataBusOut = {$urandom, $urandom};
      funct3     = 3'($urandom);
      @(posedge clk); #1; lat++;
    end
    req_valid = 1'b0;
    check({tag, "_lat"}, 64'(lat), bad ? 64'd0 : 64'(n));
    check({tag, "_err"}, 64'(resp_err), 64'(bad));
    check({tag, "_data"}, DataBusIn, exp_data);
    got = DataBusIn;
    @(posedge clk); #1;
    check({tag, "_strobe1"}, 64'(resp_valid), 64'd0);
    check({tag, "_idle"}, 64'(req_ready), 64'd1);
    check({tag, "_hold"}, DataBusIn, exp_data);
  endtask

  task automatic do_ignored(input string tag, input logic [2:0] ctrl);
    req_valid  = 1'b1;
    ControlBus = {2'b00, ctrl[0]};
    AddressBus = {$urandom, $urandom};
    DataBusOut = {$urandom, $urandom};
    funct3     = 3'($urandom);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check({tag, "_noresp"}, 64'(resp_valid), 64'd0);
      check({tag, "_ready"}, 64'(req_ready), 64'd1);
    end
    req_valid = 1'b0;
  endtask

  initial begin
    logic [63:0] got;
    int bad_bytes;
    for (int i = 0; i < 4096; i++) model_mem[i] = 8'h00;

    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(resp_valid), 64'd0);
    check("rst_err", 64'(resp_err), 64'd0);
    check("rst_data", DataBusIn, 64'd0);
    check("rst_ready", 64'(req_ready), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;

    do_req("sd10", 3'b100, 64'h10, 64'h1122334455667788, 3'b011, got);
    do_req("ld10", 3'b011, 64'h10, 64'h0, 3'b011, got);
    check("ld10_tp", got, 64'h1122334455667788);
    check("mem10", 64'(dut.mem_q[12'h010]), 64'h88);

    do_req("sb20", 3'b100, 64'h20, 64'hAB80, 3'b000, got);
    check("mem20", 64'(dut.mem_q[12'h020]), 64'h80);
    check("mem21", 64'(dut.mem_q[12'h021]), 64'h00);
    do_req("lb20", 3'b010, 64'h20, 64'h0, 3'b000, got);
    check("lb20_tp", got, 64'hFFFFFFFFFFFFFF80);
    do_req("lbu20", 3'b010, 64'h20, 64'h0, 3'b100, got);
    check("lbu20_tp", got, 64'h0000000000000080);

    do_req("swwrap", 3'b100, 64'hFFE, 64'hDEADBEEF, 3'b010, got);
    check("memFFE", 64'(dut.mem_q[12'hFFE]), 64'hEF);
    check("memFFF", 64'(dut.mem_q[12'hFFF]), 64'hBE);
    check("mem000", 64'(dut.mem_q[12'h000]), 64'hAD);
    check("mem001", 64'(dut.mem_q[12'h001]), 64'hDE);
    do_req("lwwrap", 3'b010, 64'hFFE, 64'h0, 3'b010, got);
    check("lwwrap_tp", got, 64'hFFFFFFFFDEADBEEF);
    do_req("lwuwrap", 3'b010, 64'hFFE, 64'h0, 3'b110, got);
    check("lwuwrap_tp", got, 64'h00000000DEADBEEF);
    do_req("lwalias", 3'b010, 64'h1FFE, 64'h0, 3'b010, got);
    check("lwalias_tp", got, 64'hFFFFFFFFDEADBEEF);

    do_req("err_both", 3'b110, 64'h10, 64'hFFFFFFFFFFFFFFFF, 3'b000, got);
    do_req("err_ld111", 3'b010, 64'h10, 64'h0, 3'b111, got);
    do_req("err_st100", 3'b100, 64'h10, 64'hFFFFFFFFFFFFFFFF, 3'b100, got);
    check("mem10_keep", 64'(dut.mem_q[12'h010]), 64'h88);

    do_ignored("ign", 3'b001);

    // Reset after three bytes of an sd over zeroed memory at 0x40.
    req_valid  = 1'b1;
    ControlBus = 3'b100;
    AddressBus = 64'h40;
    DataBusOut = 64'hFFFFFFFFFFFFFFFF;
    funct3     = 3'b011;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("mid_noresp", 64'(resp_valid), 64'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    check("mid_rst_noresp", 64'(resp_valid), 64'd0);
    check("mid_rst_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    check("mid_after_noresp", 64'(resp_valid), 64'd0);
    check("mid_after_ready", 64'(req_ready), 64'd1);
    check("mid_after_data", DataBusIn, 64'd0);
    for (int i = 0; i < 3; i++) model_mem[12'h040 + i] = 8'hFF;
    for (int i = 0; i < 8; i++)
      check("mid_mem", 64'(dut.mem_q[12'h040 + i]), 64'(model_mem[12'h040 + i]));
    do_req("mid_ld", 3'b011, 64'h40, 64'h0, 3'b011, got);
    check("mid_ld_tp", got, 64'h0000000000FFFFFF);

    for (int k = 0; k < 300; k++) begin
      logic [2:0]  c, f;
      logic [63:0] ad;
      c = 3'($urandom);
      f = 3'($urandom);
      case ($urandom_range(0, 2))
        0: ad = 64'($urandom_range(0, 63));
        1: ad = 64'($urandom_range(4088, 4095)) | (64'($urandom) << 12);
        default: ad = {$urandom, $urandom};
      endcase
      if (c[2:1] == 2'b00) do_ignored("rnd_ign", c);
      else do_req("rnd", c, ad, {$urandom, $urandom}, f, got);
    end

    bad_bytes = 0;
    for (int i = 0; i < 4096; i++)
      if (dut.mem_q[i] !== model_mem[i]) bad_bytes++;
    check("mem_all", 64'(bad_bytes), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
